// File: rtl/o_ddr_gearbox.sv
// ============================================================================
// o_ddr_gearbox : parallel word to DDR pair gearbox feeding an O_DDR primitive
// Rev 1.0
// ============================================================================
`default_nettype none

module o_ddr_gearbox #(
   parameter int   WIDTH      = 8,
   parameter bit   MSB_FIRST  = 1'b0,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             C,
   input  logic             R,
   input  logic [WIDTH-1:0] D_IN,
   input  logic             VALID,
   output logic             READY,
   output logic [1:0]       DQ,
   output logic             ACTIVE,
   output logic             WORD_START,
   output logic             UNDERRUN
);

   localparam int N  = WIDTH / 2;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] N_CNT   = CW'(N);
   localparam logic [CW-1:0] ONE_CNT = CW'(1);

   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [1:0]       dq_q, dq_d;
   logic             active_q, active_d;
   logic             word_start_q, word_start_d;
   logic             underrun_q, underrun_d;

   logic [1:0]       w_pair;
   logic [WIDTH-1:0] w_shifted;
   logic             w_ready;

   assign w_ready = !hold_full_q && !R;

   // Pair bit order is {falling, rising}; MSB-first sends the top bit on the rising edge.
   assign w_pair    = MSB_FIRST ? {shift_q[WIDTH-2], shift_q[WIDTH-1]} : shift_q[1:0];
   assign w_shifted = MSB_FIRST ? (shift_q << 2) : (shift_q >> 2);

   always_comb begin
      hold_d       = hold_q;
      hold_full_d  = hold_full_q;
      shift_d      = shift_q;
      cnt_d        = cnt_q;
      dq_d         = {2{IDLE_LEVEL}};
      active_d     = 1'b0;
      word_start_d = 1'b0;
      underrun_d   = (cnt_q == '0) && active_q;

      if (cnt_q != '0) begin
         dq_d         = w_pair;
         active_d     = 1'b1;
         word_start_d = (cnt_q == N_CNT);
         shift_d      = w_shifted;
         cnt_d        = cnt_q - ONE_CNT;
      end

      // Reloading on the last pair keeps the output stream gapless.
      if ((cnt_q <= ONE_CNT) && hold_full_q) begin
         shift_d     = hold_q;
         cnt_d       = N_CNT;
         hold_full_d = 1'b0;
      end

      if (VALID && w_ready) begin
         hold_d      = D_IN;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge C or posedge R) begin
      if (R) begin
         hold_q       <= '0;
         hold_full_q  <= 1'b0;
         shift_q      <= '0;
         cnt_q        <= '0;
         dq_q         <= {2{IDLE_LEVEL}};
         active_q     <= 1'b0;
         word_start_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         hold_q       <= hold_d;
         hold_full_q  <= hold_full_d;
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         dq_q         <= dq_d;
         active_q     <= active_d;
         word_start_q <= word_start_d;
         underrun_q   <= underrun_d;
      end
   end

   assign READY      = w_ready;
   assign DQ         = dq_q;
   assign ACTIVE     = active_q;
   assign WORD_START = word_start_q;
   assign UNDERRUN   = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_o_ddr_gearbox.sv
// ============================================================================
// tb_o_ddr_gearbox : directed checks of o_ddr_gearbox (LSB-first and MSB-first)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_o_ddr_gearbox;

   logic       clk;
   logic       r;
   logic [7:0] din, din_m;
   logic       valid, valid_m;
   logic       ready, ready_m;
   logic [1:0] dq, dq_m;
   logic       active, active_m;
   logic       ws, ws_m;
   logic       ur, ur_m;

   int n_vec;
   int n_err;

   o_ddr_gearbox #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
      .C(clk), .R(r), .D_IN(din), .VALID(valid), .READY(ready),
      .DQ(dq), .ACTIVE(active), .WORD_START(ws), .UNDERRUN(ur)
   );

   o_ddr_gearbox #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
      .C(clk), .R(r), .D_IN(din_m), .VALID(valid_m), .READY(ready_m),
      .DQ(dq_m), .ACTIVE(active_m), .WORD_START(ws_m), .UNDERRUN(ur_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic [1:0] exp_b2b [8];
   logic       exp_ws8 [8];
   logic [1:0] exp_msb [4];

   initial begin
      n_vec = 0;
      n_err = 0;
      exp_b2b = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b00};
      exp_ws8 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      exp_msb = '{2'b01, 2'b11, 2'b10, 2'b00};

      // Reset held with VALID asserted
      r = 1'b1; valid = 1'b1; din = 8'hB4; valid_m = 1'b0; din_m = 8'h00;
      repeat (2) tick();
      check("rst_ready", {7'd0, ready}, 8'd0);
      check("rst_dq", {6'd0, dq}, 8'd0);
      check("rst_active", {7'd0, active}, 8'd0);
      check("rst_ws", {7'd0, ws}, 8'd0);
      check("rst_ur", {7'd0, ur}, 8'd0);
      check("rst_ready_m", {7'd0, ready_m}, 8'd0);
      valid = 1'b0;
      r = 1'b0;
      #1;
      check("rel_ready", {7'd0, ready}, 8'd1);

      // Single word 8'hB4, LSB first
      valid = 1'b1; din = 8'hB4;
      tick();
      valid = 1'b0;
      check("single_ready_full", {7'd0, ready}, 8'd0);
      tick();
      check("single_k1_active", {7'd0, active}, 8'd0);
      check("single_k1_ready", {7'd0, ready}, 8'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("single_dq", {6'd0, dq}, {6'd0, exp_b2b[i]});
         check("single_ws", {7'd0, ws}, {7'd0, exp_ws8[i]});
         check("single_active", {7'd0, active}, 8'd1);
      end
      tick();
      check("single_idle_dq", {6'd0, dq}, 8'd0);
      check("single_idle_active", {7'd0, active}, 8'd0);
      check("single_ur", {7'd0, ur}, 8'd1);
      tick();
      check("single_ur_clear", {7'd0, ur}, 8'd0);

      // Back-to-back 8'hB4 then 8'h1E
      valid = 1'b1; din = 8'hB4;
      tick();
      din = 8'h1E;
      check("b2b_ready_k", {7'd0, ready}, 8'd0);
      tick();
      check("b2b_ready_k1", {7'd0, ready}, 8'd1);
      tick();
      valid = 1'b0;
      check("b2b_ready_k2", {7'd0, ready}, 8'd0);
      check("b2b_dq0", {6'd0, dq}, 8'd0);
      check("b2b_ws0", {7'd0, ws}, 8'd1);
      for (int i = 1; i < 8; i++) begin
         tick();
         check("b2b_dq", {6'd0, dq}, {6'd0, exp_b2b[i]});
         check("b2b_ws", {7'd0, ws}, {7'd0, exp_ws8[i]});
         check("b2b_active", {7'd0, active}, 8'd1);
         check("b2b_ur", {7'd0, ur}, 8'd0);
      end
      tick();
      check("b2b_end_active", {7'd0, active}, 8'd0);
      check("b2b_end_ur", {7'd0, ur}, 8'd1);
      tick();

      // MSB-first instance, word 8'hB4
      valid_m = 1'b1; din_m = 8'hB4;
      tick();
      valid_m = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         check("msb_dq", {6'd0, dq_m}, {6'd0, exp_msb[i]});
         check("msb_ws", {7'd0, ws_m}, {7'd0, exp_ws8[i]});
      end
      tick();
      check("msb_ur", {7'd0, ur_m}, 8'd1);
      tick();

      // Refill at k+4: gapless
      valid = 1'b1; din = 8'hB4;
      tick();
      valid = 1'b0;
      repeat (3) tick();
      valid = 1'b1; din = 8'h1E;
      tick();
      valid = 1'b0;
      check("refill4_k4_dq", {6'd0, dq}, 8'b11);
      tick();
      check("refill4_k5_dq", {6'd0, dq}, 8'b10);
      tick();
      check("refill4_k6_dq", {6'd0, dq}, 8'b10);
      check("refill4_k6_ws", {7'd0, ws}, 8'd1);
      check("refill4_k6_ur", {7'd0, ur}, 8'd0);
      check("refill4_k6_active", {7'd0, active}, 8'd1);
      repeat (3) tick();
      tick();
      check("refill4_end_ur", {7'd0, ur}, 8'd1);
      tick();

      // Refill at k+5: one idle cycle with UNDERRUN
      valid = 1'b1; din = 8'hB4;
      tick();
      valid = 1'b0;
      repeat (4) tick();
      valid = 1'b1; din = 8'h1E;
      tick();
      valid = 1'b0;
      check("refill5_k5_dq", {6'd0, dq}, 8'b10);
      tick();
      check("refill5_k6_dq", {6'd0, dq}, 8'b00);
      check("refill5_k6_active", {7'd0, active}, 8'd0);
      check("refill5_k6_ur", {7'd0, ur}, 8'd1);
      tick();
      check("refill5_k7_dq", {6'd0, dq}, 8'b10);
      check("refill5_k7_ws", {7'd0, ws}, 8'd1);
      repeat (3) tick();
      tick();
      check("refill5_end_ur", {7'd0, ur}, 8'd1);
      tick();

      // Asynchronous reset mid-word
      valid = 1'b1; din = 8'hB4;
      tick();
      valid = 1'b0;
      repeat (3) tick();
      check("midrst_pre_dq", {6'd0, dq}, 8'b01);
      check("midrst_pre_active", {7'd0, active}, 8'd1);
      #2;
      r = 1'b1;
      #1;
      check("midrst_dq", {6'd0, dq}, 8'd0);
      check("midrst_active", {7'd0, active}, 8'd0);
      check("midrst_ready", {7'd0, ready}, 8'd0);
      #1;
      r = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("postrst_active", {7'd0, active}, 8'd0);
         check("postrst_dq", {6'd0, dq}, 8'd0);
      end
      check("postrst_ur", {7'd0, ur}, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
